ofs_plat_axi_mem_rsp_credit_ctrl: RTL
=====================================

OFS_PLAT_AXI_MEM_RSP_CREDIT_CTRL -- requirements
Module: ofs_plat_axi_mem_rsp_credit_ctrl

Interface
REQ-001 Parameter NUM_READ_CREDITS, default 256: read-data beat buffer slots reserved downstream; range 2..4096.
REQ-002 Parameter NUM_WRITE_CREDITS, default 128: write-response slots reserved downstream; range 2..4096.
REQ-003 Parameter LEN_WIDTH, default 8: width of AXI arlen.
REQ-004 Port clk  in  1  single clock for all logic.
REQ-005 Port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 Port src_arvalid  in  1 / src_arlen  in  LEN_WIDTH / src_arready  out  1  read request from source.
REQ-007 Port snk_arvalid  out  1 / snk_arready  in  1  read request toward sink.
REQ-008 Port src_awvalid  in  1 / src_awready  out  1 / snk_awvalid  out  1 / snk_awready  in  1  write address path.
REQ-009 Port r_beat_done  in  1  one R beat consumed by source (rvalid && rready).
REQ-010 Port b_done  in  1  one B response consumed by source (bvalid && bready).
REQ-011 Port drain_req  in  1 / drain_ack  out  1  quiesce handshake.
REQ-012 Port rd_credits  out  $clog2(NUM_READ_CREDITS+1) / wr_credits  out  $clog2(NUM_WRITE_CREDITS+1)  credits currently available.
REQ-013 Port credit_err  out  1  sticky: a credit return would exceed the maximum.

Function
REQ-014 Read request admitted only if state==RUN and rd_credits >= src_arlen+1; arithmetic is one bit wider than LEN_WIDTH, so arlen=255 requires 256.
REQ-015 snk_arvalid = src_arvalid && admit_rd; src_arready = snk_arready && admit_rd; combinational, zero added latency.
REQ-016 Write request admitted only if state==RUN and wr_credits >= 1; snk_awvalid/src_awready formed as in REQ-015.
REQ-017 AR handshake (src_arvalid && src_arready) subtracts arlen+1 from rd_credits at the next edge; r_beat_done adds 1 in the same update; simultaneous events net correctly.
REQ-018 AW handshake subtracts 1 from wr_credits; b_done adds 1; simultaneous events net to zero change.
REQ-019 Return that would push a counter above its maximum: counter saturates at maximum, credit_err sets and holds until reset.
REQ-020 An admission decision depends only on registered credit counts; credits returned in cycle N become usable in cycle N+1.
REQ-021 FSM states RUN, DRAIN, DRAINED. RUN->DRAIN when drain_req=1. DRAIN->DRAINED when both counters equal their maxima. DRAINED->RUN when drain_req=0. DRAIN->RUN when drain_req drops before completion.
REQ-022 In DRAIN and DRAINED no new AR/AW is admitted; returns are still counted.
REQ-023 drain_ack = 1 only in DRAINED, registered.
REQ-024 Requests held by the source stay pending (valid stable) across drain; no request is dropped.

Reset
REQ-025 On reset_n=0, asynchronously: rd_credits=NUM_READ_CREDITS, wr_credits=NUM_WRITE_CREDITS, state=RUN, drain_ack=0, credit_err=0.
REQ-026 During reset snk_arvalid, snk_awvalid, src_arready and src_awready are 0.
REQ-027 Reset mid-operation discards all outstanding accounting. The owner resets the downstream shim in the same reset domain.

Structure
REQ-028 Package ofs_plat_axi_mem_credit_pkg holds the FSM state enum (t_credit_drain_state) and the credit-width helper constant functions.
REQ-029 One sub-module, ofs_plat_prim_credit_counter: parameterized max, subtract-amount input, add-one input, saturation, and error flag. It is instantiated once for reads and once for writes.
REQ-030 No FIFOs or storage beyond the counters, the FSM and the error flag.

Verification
REQ-031 After reset, AR with arlen=255 and snk_arready=1 -> accepted in cycle 1; rd_credits=0 next cycle; a second AR with arlen=0 is blocked until one r_beat_done, then admitted one cycle later.
REQ-032 128 AWs back to back -> all accepted; the 129th is blocked, src_awready=0; one b_done -> accepted the following cycle; wr_credits returns to 0.
REQ-033 AR handshake with arlen=3 in the same cycle as r_beat_done, with rd_credits=10 -> rd_credits=7.
REQ-034 drain_req=1 with 5 R beats and 2 B responses outstanding -> no admissions; drain_ack rises one cycle after the last return; drain_req=0 -> admissions resume the next cycle.
REQ-035 r_beat_done with rd_credits=256 -> credit_err=1 and stays 1; rd_credits remains 256.
REQ-036 Assert reset_n=0 mid-burst with rd_credits=17 -> rd_credits=256, state RUN, and both valids 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ofs_plat_axi_mem_rsp_credit_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ofs_plat_axi_mem_credit_pkg
//
// Shared definitions for the AXI memory response credit controller:
//   - t_credit_drain_state : quiesce FSM state encoding
//   - credit_cnt_width()   : bits needed to hold a count of 0..max_credits
//   - max_width()          : larger of two widths, used to size comparisons
// ----------------------------------------------------------------------------
package ofs_plat_axi_mem_credit_pkg;

    typedef enum logic [1:0] {
        CREDIT_RUN     = 2'd0,
        CREDIT_DRAIN   = 2'd1,
        CREDIT_DRAINED = 2'd2
    } t_credit_drain_state;

    function automatic int credit_cnt_width(input int max_credits);
        return $clog2(max_credits + 1);
    endfunction

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ofs_plat_axi_mem_rsp_credit_ctrl_if.sv
// ----------------------------------------------------------------------------
// ofs_plat_axi_mem_rsp_credit_ctrl_if
//
// AR/AW handshake bundle passing through the credit controller.
//   src_* : request side coming from the source (arvalid/arlen/awvalid in,
//           arready/awready back to the source)
//   snk_* : request side going toward the sink (arvalid/awvalid out,
//           arready/awready back from the sink)
// Modports:
//   master : the environment (source and sink together)
//   slave  : the credit controller
// ----------------------------------------------------------------------------
interface ofs_plat_axi_mem_rsp_credit_ctrl_if #(
    parameter int LEN_WIDTH = 8
);

    logic                 src_arvalid;
    logic [LEN_WIDTH-1:0] src_arlen;
    logic                 src_arready;
    logic                 snk_arvalid;
    logic                 snk_arready;

    logic                 src_awvalid;
    logic                 src_awready;
    logic                 snk_awvalid;
    logic                 snk_awready;

    modport master (
        output src_arvalid, src_arlen, snk_arready, src_awvalid, snk_awready,
        input  src_arready, snk_arvalid, src_awready, snk_awvalid
    );

    modport slave (
        input  src_arvalid, src_arlen, snk_arready, src_awvalid, snk_awready,
        output src_arready, snk_arvalid, src_awready, snk_awvalid
    );

endinterface

// File: rtl/ofs_plat_axi_mem_rsp_credit_ctrl_credit_counter.sv
// ----------------------------------------------------------------------------
// ofs_plat_prim_credit_counter
//
// Saturating credit counter. Starts full (MAX_CREDITS) at reset, subtracts
// sub_amt when sub_en is set and adds one when add_one is set, both in the
// same update. A result above MAX_CREDITS saturates at MAX_CREDITS and sets
// the sticky err flag, which only reset clears.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   sub_en, sub_amt   : consume sub_amt credits this cycle
//   add_one           : one credit returned this cycle
//   count             : credits currently available (registered)
//   err               : sticky over-return indication
// ----------------------------------------------------------------------------
module ofs_plat_prim_credit_counter
    import ofs_plat_axi_mem_credit_pkg::*;
#(
    parameter int MAX_CREDITS = 256,
    parameter int SUB_WIDTH   = 9,
    parameter int CNT_WIDTH   = 9
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sub_en,
    input  logic [SUB_WIDTH-1:0] sub_amt,
    input  logic                 add_one,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 err
);

    // One extra bit over the wider operand so an over-return is visible
    // as a value above the maximum rather than wrapping.
    localparam int EXT_W = max_width(CNT_WIDTH, SUB_WIDTH) + 1;
    localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(MAX_CREDITS);

    logic [EXT_W-1:0] next_ext;
    logic             overflow;

    always_comb begin
        next_ext = EXT_W'(count) + EXT_W'(add_one);
        if (sub_en) begin
            next_ext = next_ext - EXT_W'(sub_amt);
        end
        overflow = (next_ext > MAX_EXT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= CNT_WIDTH'(MAX_CREDITS);
            err   <= 1'b0;
        end else begin
            if (overflow) begin
                count <= CNT_WIDTH'(MAX_CREDITS);
                err   <= 1'b1;
            end else begin
                count <= CNT_WIDTH'(next_ext);
            end
        end
    end

endmodule

// File: rtl/ofs_plat_axi_mem_rsp_credit_ctrl.sv
// ----------------------------------------------------------------------------
// ofs_plat_axi_mem_rsp_credit_ctrl
//
// Gates AXI AR/AW requests so that a request only reaches the sink when the
// downstream response buffering (read beats, write responses) has room for
// everything the request will return. Credits are consumed on the request
// handshake and returned as the source consumes R beats / B responses.
// A drain handshake stops new admissions and acknowledges once every credit
// has come home.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   bus                     : AR/AW handshakes (slave modport)
//   r_beat_done, b_done     : one R beat / one B response consumed
//   drain_req, drain_ack    : quiesce request / registered acknowledge
//   rd_credits, wr_credits  : credits currently available
//   credit_err              : sticky, a return exceeded the maximum
// ----------------------------------------------------------------------------
module ofs_plat_axi_mem_rsp_credit_ctrl
    import ofs_plat_axi_mem_credit_pkg::*;
#(
    parameter int NUM_READ_CREDITS  = 256,
    parameter int NUM_WRITE_CREDITS = 128,
    parameter int LEN_WIDTH         = 8,
    localparam int RD_CNT_W = credit_cnt_width(NUM_READ_CREDITS),
    localparam int WR_CNT_W = credit_cnt_width(NUM_WRITE_CREDITS)
) (
    input  logic                clk,
    input  logic                reset_n,
    ofs_plat_axi_mem_rsp_credit_ctrl_if.slave bus,
    input  logic                r_beat_done,
    input  logic                b_done,
    input  logic                drain_req,
    output logic                drain_ack,
    output logic [RD_CNT_W-1:0] rd_credits,
    output logic [WR_CNT_W-1:0] wr_credits,
    output logic                credit_err
);

    // arlen+1 needs one bit more than arlen so that arlen=max asks for
    // the full power-of-two beat count.
    localparam int NEED_W = LEN_WIDTH + 1;
    localparam int CMP_W  = max_width(RD_CNT_W, NEED_W);

    t_credit_drain_state state, state_next;

    logic [NEED_W-1:0] rd_need;
    logic              admit_rd;
    logic              admit_wr;
    logic              ar_fire;
    logic              aw_fire;
    logic              rd_err;
    logic              wr_err;
    logic              all_home;

    // Admission looks only at registered counts, so a credit returned this
    // cycle is usable next cycle. reset_n is folded in so nothing is
    // offered to either side while reset is held.
    always_comb begin
        rd_need  = NEED_W'(bus.src_arlen) + NEED_W'(1);
        admit_rd = reset_n && (state == CREDIT_RUN) &&
                   (CMP_W'(rd_credits) >= CMP_W'(rd_need));
        admit_wr = reset_n && (state == CREDIT_RUN) && (wr_credits != '0);
    end

    assign bus.snk_arvalid = bus.src_arvalid && admit_rd;
    assign bus.src_arready = bus.snk_arready && admit_rd;
    assign bus.snk_awvalid = bus.src_awvalid && admit_wr;
    assign bus.src_awready = bus.snk_awready && admit_wr;

    assign ar_fire = bus.src_arvalid && bus.src_arready;
    assign aw_fire = bus.src_awvalid && bus.src_awready;

    ofs_plat_prim_credit_counter #(
        .MAX_CREDITS (NUM_READ_CREDITS),
        .SUB_WIDTH   (NEED_W),
        .CNT_WIDTH   (RD_CNT_W)
    ) rd_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .sub_en  (ar_fire),
        .sub_amt (rd_need),
        .add_one (r_beat_done),
        .count   (rd_credits),
        .err     (rd_err)
    );

    ofs_plat_prim_credit_counter #(
        .MAX_CREDITS (NUM_WRITE_CREDITS),
        .SUB_WIDTH   (1),
        .CNT_WIDTH   (WR_CNT_W)
    ) wr_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .sub_en  (aw_fire),
        .sub_amt (1'b1),
        .add_one (b_done),
        .count   (wr_credits),
        .err     (wr_err)
    );

    assign credit_err = rd_err || wr_err;

    assign all_home = (rd_credits == RD_CNT_W'(NUM_READ_CREDITS)) &&
                      (wr_credits == WR_CNT_W'(NUM_WRITE_CREDITS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CREDIT_RUN;
            drain_ack <= 1'b0;
        end else begin
            state     <= state_next;
            drain_ack <= (state_next == CREDIT_DRAINED);
        end
    end

    // Dropping drain_req always returns to RUN, whether or not the drain
    // had completed.
    always_comb begin
        state_next = state;
        case (state)
            CREDIT_RUN: begin
                if (drain_req) state_next = CREDIT_DRAIN;
            end
            CREDIT_DRAIN: begin
                if (!drain_req)    state_next = CREDIT_RUN;
                else if (all_home) state_next = CREDIT_DRAINED;
            end
            CREDIT_DRAINED: begin
                if (!drain_req) state_next = CREDIT_RUN;
            end
            default: state_next = CREDIT_RUN;
        endcase
    end

endmodule
